tick_scheduler: RTL and testbench
=================================

Name: tick_scheduler

Overview:
Central clock-enable scheduler for the vending machine. It runs on the single board clock and generates one-cycle enable pulses for the slower subsystems: button debounce, display refresh and the one-second timebase. It also owns a programmable countdown timer, clocked by the seconds timebase, that the vending FSM uses for inactivity and dispense timeouts. Consumers use the tick outputs as clock enables on clock_in; no derived clocks leave this block.

Parameters:
DEB_DIV, 4, debounce tick period in clock_in cycles (>=2)
REF_DIV, 8, display refresh tick period in clock_in cycles (>=2)
SEC_DIV, 16, seconds tick period in clock_in cycles (>=2); top level overrides with board values
TIMER_W, 8, width of timer load value and remaining count

Ports:
clock_in  input  1  system clock, all logic on its rising edge
reset  input  1  synchronous, active-high reset
enable  input  1  global run; 0 freezes all prescalers and the timer
timer_start  input  1  one-cycle pulse; load timer_val and run
timer_val  input  TIMER_W  timeout in seconds, sampled when timer_start=1
timer_cancel  input  1  one-cycle pulse; abort the timer with no expiry
tick_debounce  output  1  one-cycle pulse every DEB_DIV cycles
tick_refresh  output  1  one-cycle pulse every REF_DIV cycles
tick_second  output  1  one-cycle pulse every SEC_DIV cycles
timer_busy  output  1  high while the timer is in RUN
timer_remaining  output  TIMER_W  seconds left; 0 when idle
timer_expired  output  1  one-cycle pulse on timeout

Behaviour:
- Interface: one clock, clock_in; reset is synchronous and active-high on port reset. Reset overrides every other input on the same edge.
- Reset values: all outputs 0, all prescaler counters 0, timer FSM in IDLE.
- Prescalers (one per DIV), each with counter cnt of width clog2(DIV):
  - enable=1 and cnt==DIV-1: cnt<=0, tick<=1.
  - enable=1, any other cnt: cnt<=cnt+1, tick<=0.
  - enable=0: cnt holds, tick<=0.
  - Every tick is a registered pulse, exactly one cycle wide, with period exactly DIV enabled cycles.
  - After reset release with enable held high, the first tick is high in the cycle after the DIV-th rising edge.
- The internal "sec_wrap" term (enable & cnt_sec==SEC_DIV-1) drives tick_second and the timer on the same edge.
- Timer FSM, states IDLE and RUN:
  - IDLE, timer_start=1, timer_val!=0: remaining<=timer_val, busy<=1, enter RUN. cnt_sec<=0 on the same edge, so a timeout of N lasts exactly N*SEC_DIV enabled cycles.
  - IDLE, timer_start=1, timer_val==0: timer_expired<=1 on the next edge. Stay in IDLE; busy never rises.
  - RUN, sec_wrap with remaining>1: remaining<=remaining-1.
  - RUN, sec_wrap with remaining==1: remaining<=0, busy<=0, timer_expired<=1 for one cycle, enter IDLE.
  - RUN, timer_start=1: reload timer_val and realign cnt_sec<=0. Start has priority over a decrement on the same edge. A start with timer_val==0 in RUN follows the IDLE zero-value rule and returns to IDLE.
  - timer_cancel=1 in any state: enter IDLE, remaining<=0, busy<=0, no expired pulse. Cancel beats start on the same edge.
  - enable=0 freezes the timer, including start and cancel? No: start and cancel are still honoured; only decrementing is frozen.
- timer_expired and tick_second may be high in the same cycle.
- Arithmetic is unsigned. The remaining count never wraps below 0.
- An elaboration-time check errors out if any DIV parameter is less than 2.

Test Plan:
1. Defaults; release reset; enable=1 constant -> tick_debounce high after edges 4, 8, 12…; tick_refresh after edges 8, 16…; tick_second after edges 16, 32…; every pulse exactly 1 cycle wide.
2. enable=1 for 6 cycles, then 0 for 10, then 1 -> no ticks while low, counters hold. The next tick_debounce arrives 2 enabled cycles later; every subsequent tick is shifted by exactly 10 cycles.
3. timer_start with timer_val=3 at edge k -> busy=1 and remaining=3 after k. remaining reads 2, 1, 0 after edges k+16, k+32, k+48. timer_expired is high for one cycle after k+48, then busy=0.
4. timer_start with timer_val=0 -> timer_expired high for one cycle on the next edge; busy and remaining stay 0.
5. Start with val=5; 20 cycles later start with val=2 -> remaining=2, expiry exactly 32 cycles after the second start. Separately, start and cancel on the same edge during RUN -> IDLE, remaining=0, no expired pulse.
6. Start with val=4; assert reset 30 cycles later -> on the next edge all outputs are 0 and the FSM is IDLE. No expired pulse ever follows; with enable=1 the first post-reset tick_second comes 16 edges after reset deasserts.

Source files
------------

// File: rtl/tick_scheduler.sv
// tick_scheduler: clock-enable scheduler for the vending machine.
//
// Makes single-cycle enable pulses for the debounce, display-refresh and
// one-second timebases from clock_in, and runs a countdown timer that the
// vending FSM uses for timeouts. The timer counts in seconds ticks. No clocks
// are derived here; consumers use the ticks as clock enables.
//
// Ports:
//   clock_in        system clock, rising edge
//   reset           synchronous, active-high; overrides all other inputs
//   enable          global run; low freezes prescalers and timer decrement
//   timer_start     one-cycle pulse: load timer_val and run
//   timer_val       timeout in seconds, sampled with timer_start
//   timer_cancel    one-cycle pulse: abort the timer, no expiry (beats start)
//   tick_debounce   one-cycle pulse every DEB_DIV enabled cycles
//   tick_refresh    one-cycle pulse every REF_DIV enabled cycles
//   tick_second     one-cycle pulse every SEC_DIV enabled cycles
//   timer_busy      high while the timer runs
//   timer_remaining seconds left, 0 when idle
//   timer_expired   one-cycle pulse on timeout
module tick_scheduler #(
  parameter int unsigned DEB_DIV = 4,
  parameter int unsigned REF_DIV = 8,
  parameter int unsigned SEC_DIV = 16,
  parameter int unsigned TIMER_W = 8
) (
  input  logic               clock_in,
  input  logic               reset,
  input  logic               enable,
  input  logic               timer_start,
  input  logic [TIMER_W-1:0] timer_val,
  input  logic               timer_cancel,
  output logic               tick_debounce,
  output logic               tick_refresh,
  output logic               tick_second,
  output logic               timer_busy,
  output logic [TIMER_W-1:0] timer_remaining,
  output logic               timer_expired
);

  if (DEB_DIV < 2 || REF_DIV < 2 || SEC_DIV < 2) begin : gen_div_check
    $error("tick_scheduler: every DIV parameter must be at least 2");
  end

  localparam int unsigned DebW = $clog2(DEB_DIV);
  localparam int unsigned RefW = $clog2(REF_DIV);
  localparam int unsigned SecW = $clog2(SEC_DIV);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  logic [DebW-1:0]    deb_cnt_q, deb_cnt_d;
  logic [RefW-1:0]    ref_cnt_q, ref_cnt_d;
  logic [SecW-1:0]    sec_cnt_q, sec_cnt_d;
  logic               deb_tick_q, deb_tick_d;
  logic               ref_tick_q, ref_tick_d;
  logic               sec_tick_q, sec_tick_d;
  state_e             state_q, state_d;
  logic [TIMER_W-1:0] rem_q, rem_d;
  logic               busy_q, busy_d;
  logic               expired_q, expired_d;

  logic deb_wrap, ref_wrap, sec_wrap;
  logic sec_realign;

  assign deb_wrap = enable && (deb_cnt_q == DebW'(DEB_DIV - 1));
  assign ref_wrap = enable && (ref_cnt_q == RefW'(REF_DIV - 1));
  assign sec_wrap = enable && (sec_cnt_q == SecW'(SEC_DIV - 1));

  // Timer next state. Cancel beats start; start beats a decrement.
  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    busy_d      = busy_q;
    expired_d   = 1'b0;
    sec_realign = 1'b0;
    if (timer_cancel) begin
      state_d = StIdle;
      rem_d   = '0;
      busy_d  = 1'b0;
    end else if (timer_start) begin
      if (timer_val != '0) begin
        state_d     = StRun;
        rem_d       = timer_val;
        busy_d      = 1'b1;
        // Restart the seconds phase so N seconds is exactly N*SEC_DIV cycles.
        sec_realign = 1'b1;
      end else begin
        state_d   = StIdle;
        rem_d     = '0;
        busy_d    = 1'b0;
        expired_d = 1'b1;
      end
    end else if (state_q == StRun && sec_wrap) begin
      if (rem_q > TIMER_W'(1)) begin
        rem_d = rem_q - TIMER_W'(1);
      end else begin
        state_d   = StIdle;
        rem_d     = '0;
        busy_d    = 1'b0;
        expired_d = 1'b1;
      end
    end
  end

  // Prescalers: count only while enabled, wrap at DIV-1.
  always_comb begin
    deb_cnt_d  = deb_cnt_q;
    ref_cnt_d  = ref_cnt_q;
    sec_cnt_d  = sec_cnt_q;
    deb_tick_d = deb_wrap;
    ref_tick_d = ref_wrap;
    sec_tick_d = sec_wrap;
    if (enable) begin
      deb_cnt_d = deb_wrap ? '0 : deb_cnt_q + DebW'(1);
      ref_cnt_d = ref_wrap ? '0 : ref_cnt_q + RefW'(1);
      sec_cnt_d = sec_wrap ? '0 : sec_cnt_q + SecW'(1);
    end
    if (sec_realign) begin
      sec_cnt_d = '0;
    end
  end

  always_ff @(posedge clock_in) begin
    if (reset) begin
      deb_cnt_q  <= '0;
      ref_cnt_q  <= '0;
      sec_cnt_q  <= '0;
      deb_tick_q <= 1'b0;
      ref_tick_q <= 1'b0;
      sec_tick_q <= 1'b0;
      state_q    <= StIdle;
      rem_q      <= '0;
      busy_q     <= 1'b0;
      expired_q  <= 1'b0;
    end else begin
      deb_cnt_q  <= deb_cnt_d;
      ref_cnt_q  <= ref_cnt_d;
      sec_cnt_q  <= sec_cnt_d;
      deb_tick_q <= deb_tick_d;
      ref_tick_q <= ref_tick_d;
      sec_tick_q <= sec_tick_d;
      state_q    <= state_d;
      rem_q      <= rem_d;
      busy_q     <= busy_d;
      expired_q  <= expired_d;
    end
  end

  assign tick_debounce   = deb_tick_q;
  assign tick_refresh    = ref_tick_q;
  assign tick_second     = sec_tick_q;
  assign timer_busy      = busy_q;
  assign timer_remaining = rem_q;
  assign timer_expired   = expired_q;

endmodule

// File: tb/tb_tick_scheduler.sv
// Bench for tick_scheduler with default parameters (4/8/16, 8-bit timer).
// A vector table covers the prescalers, including a 10-cycle enable gap;
// hand-written sequences cover the timer and reset corner cases.
module tb_tick_scheduler;

  localparam int unsigned TW = 8;
  localparam int unsigned NVec = 68;

  logic          clock_in = 1'b0;
  logic          reset;
  logic          enable;
  logic          timer_start;
  logic [TW-1:0] timer_val;
  logic          timer_cancel;
  logic          tick_debounce;
  logic          tick_refresh;
  logic          tick_second;
  logic          timer_busy;
  logic [TW-1:0] timer_remaining;
  logic          timer_expired;

  tick_scheduler dut (
    .clock_in        (clock_in),
    .reset           (reset),
    .enable          (enable),
    .timer_start     (timer_start),
    .timer_val       (timer_val),
    .timer_cancel    (timer_cancel),
    .tick_debounce   (tick_debounce),
    .tick_refresh    (tick_refresh),
    .tick_second     (tick_second),
    .timer_busy      (timer_busy),
    .timer_remaining (timer_remaining),
    .timer_expired   (timer_expired)
  );

  always #5 clock_in = ~clock_in;

  typedef struct {
    logic en;
    logic deb;
    logic rfr;
    logic sec;
  } vec_t;

  vec_t vecs [NVec];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clock_in);
    #1;
  endtask

  function automatic logic [31:0] bundle();
    return {19'd0, tick_debounce, tick_refresh, tick_second, timer_busy, timer_expired,
            timer_remaining};
  endfunction

  initial begin
    int m;
    int cnt;
    int first_sec;
    int first_deb;
    int first_ref;

    // Edge i+1 after reset release; the enable gap covers table rows 38..47.
    // Ticks land on every DIV-th enabled edge counted from release.
    m = 0;
    for (int i = 0; i < NVec; i++) begin
      vecs[i].en = !(i >= 38 && i < 48);
      if (vecs[i].en) m++;
      vecs[i].deb = vecs[i].en && (m % 4 == 0);
      vecs[i].rfr = vecs[i].en && (m % 8 == 0);
      vecs[i].sec = vecs[i].en && (m % 16 == 0);
    end

    reset        = 1'b1;
    enable       = 1'b1;
    timer_start  = 1'b0;
    timer_val    = '0;
    timer_cancel = 1'b0;
    tick();
    tick();
    check("reset_state", bundle(), 32'd0);
    reset = 1'b0;

    // Prescalers
    for (int i = 0; i < NVec; i++) begin
      enable = vecs[i].en;
      tick();
      check($sformatf("vec%0d", i), bundle(),
            {19'd0, vecs[i].deb, vecs[i].rfr, vecs[i].sec, 1'b0, 1'b0, 8'd0});
    end
    enable = 1'b1;

    // Timer, value 3
    timer_start = 1'b1;
    timer_val   = 8'd3;
    tick();
    timer_start = 1'b0;
    check("t3_busy", {31'd0, timer_busy}, 32'd1);
    check("t3_load", {24'd0, timer_remaining}, 32'd3);
    repeat (15) tick();
    check("t3_hold", {24'd0, timer_remaining, 7'd0, tick_second}, {24'd3, 8'd0});
    tick();
    check("t3_dec1", {24'd0, timer_remaining, 7'd0, tick_second}, {24'd2, 8'd1});
    repeat (16) tick();
    check("t3_dec2", {24'd0, timer_remaining}, 32'd1);
    repeat (16) tick();
    check("t3_expire", {21'd0, tick_second, timer_busy, timer_expired, timer_remaining},
          {21'd0, 1'b1, 1'b0, 1'b1, 8'd0});
    tick();
    check("t3_pulse_width", {31'd0, timer_expired}, 32'd0);

    // Zero-value start
    timer_start = 1'b1;
    timer_val   = 8'd0;
    tick();
    timer_start = 1'b0;
    check("t4_zero", {22'd0, timer_busy, timer_expired, timer_remaining}, {22'd0, 2'b01, 8'd0});
    tick();
    check("t4_after", {22'd0, timer_busy, timer_expired, timer_remaining}, 32'd0);

    // Restart while running
    timer_start = 1'b1;
    timer_val   = 8'd5;
    tick();
    timer_start = 1'b0;
    repeat (19) tick();
    check("t5_before_restart", {24'd0, timer_remaining}, 32'd4);
    timer_start = 1'b1;
    timer_val   = 8'd2;
    tick();
    timer_start = 1'b0;
    check("t5_reload", {23'd0, timer_busy, timer_remaining}, {23'd0, 1'b1, 8'd2});
    repeat (31) tick();
    check("t5_pre_expire", {23'd0, timer_expired, timer_remaining}, {23'd0, 1'b0, 8'd1});
    tick();
    check("t5_expire", {22'd0, timer_busy, timer_expired, timer_remaining},
          {22'd0, 2'b01, 8'd0});

    // Start and cancel on the same edge while running
    timer_start = 1'b1;
    timer_val   = 8'd7;
    tick();
    timer_start = 1'b0;
    repeat (5) tick();
    timer_start  = 1'b1;
    timer_val    = 8'd9;
    timer_cancel = 1'b1;
    tick();
    timer_start  = 1'b0;
    timer_cancel = 1'b0;
    check("t5_cancel", {22'd0, timer_busy, timer_expired, timer_remaining}, 32'd0);
    cnt = 0;
    for (int j = 0; j < 160; j++) begin
      tick();
      if (timer_expired || timer_busy) cnt++;
    end
    check("t5_no_expiry_after_cancel", cnt, 0);

    // Plain cancel
    timer_start = 1'b1;
    timer_val   = 8'd3;
    tick();
    timer_start  = 1'b0;
    timer_cancel = 1'b1;
    tick();
    timer_cancel = 1'b0;
    check("cancel_only", {22'd0, timer_busy, timer_expired, timer_remaining}, 32'd0);

    // Start honoured with enable low; decrement frozen
    enable      = 1'b0;
    timer_start = 1'b1;
    timer_val   = 8'd2;
    tick();
    timer_start = 1'b0;
    check("en0_start", {23'd0, timer_busy, timer_remaining}, {23'd0, 1'b1, 8'd2});
    cnt = 0;
    for (int j = 0; j < 20; j++) begin
      tick();
      if (tick_second || tick_debounce || tick_refresh) cnt++;
    end
    check("en0_no_ticks", cnt, 0);
    check("en0_frozen", {24'd0, timer_remaining}, 32'd2);
    enable = 1'b1;
    repeat (31) tick();
    check("en1_pre_expire", {23'd0, timer_expired, timer_remaining}, {23'd0, 1'b0, 8'd1});
    tick();
    check("en1_expire", {22'd0, timer_busy, timer_expired, timer_remaining},
          {22'd0, 2'b01, 8'd0});

    // Reset mid-run, with a start on the same edge that reset must override
    timer_start = 1'b1;
    timer_val   = 8'd4;
    tick();
    timer_start = 1'b0;
    repeat (29) tick();
    reset       = 1'b1;
    timer_start = 1'b1;
    timer_val   = 8'd5;
    tick();
    reset       = 1'b0;
    timer_start = 1'b0;
    check("t6_reset_outputs", bundle(), 32'd0);
    cnt       = 0;
    first_sec = 0;
    first_deb = 0;
    first_ref = 0;
    for (int j = 1; j <= 70; j++) begin
      tick();
      if (timer_expired || timer_busy) cnt++;
      if (tick_second && first_sec == 0) first_sec = j;
      if (tick_debounce && first_deb == 0) first_deb = j;
      if (tick_refresh && first_ref == 0) first_ref = j;
    end
    check("t6_no_expiry", cnt, 0);
    check("t6_first_sec", first_sec, 16);
    check("t6_first_deb", first_deb, 4);
    check("t6_first_ref", first_ref, 8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
